led_serial_receiver: RTL and testbench
======================================

// Module: led_serial_receiver
// PURPOSE
// - Receive end of the LED serial link: a behavioural model of the LED driver's input stage,
//   fed by the controller's serial/sclk/lat/gsclk outputs.
// - Samples these signals on the system clock, shifts serial data and commits latched frames
//   into per-lane banks.
// - Counts grayscale clocks and flags framing errors.
// - Used as the bench-side checker for the controller and as a loopback target on hardware.
// PARAMETERS
// - SHIFT_W   48   shift-register length in bits (one frame)
// - NUM_LAT   4    number of latch lanes (width of lat)
// - GS_W      12   width of the grayscale-clock counter
// PORTS
// - clk          in   1                 system clock; all logic on its rising edge
// - rst_n        in   1                 asynchronous, active-low reset
// - serial       in   1                 serial data from controller (async to clk)
// - sclk         in   1                 shift clock from controller (async)
// - lat          in   NUM_LAT           latch strobes, one per lane (async)
// - gsclk        in   1                 grayscale clock (async)
// - err_clr      in   1                 sync pulse; clears sticky error flags
// - bank         out  NUM_LAT*SHIFT_W   latched frames; lane i at [i*SHIFT_W +: SHIFT_W]
// - latch_pulse  out  1                 1-cycle strobe when any bank updates
// - latch_idx    out  2                 lowest lane index committed on latch_pulse
// - bit_cnt      out  $clog2(SHIFT_W+1) bits shifted since last latch, saturating at SHIFT_W
// - rx_state     out  2                 0 IDLE, 1 SHIFTING, 2 FULL
// - gs_count     out  GS_W              gsclk rising edges since last latch, wraps
// - gs_wrap      out  1                 1-cycle strobe when gs_count wraps max->0
// - err_overrun  out  1                 sticky: sclk edge seen while bit_cnt==SHIFT_W
// - err_short    out  1                 sticky: latch seen while bit_cnt!=SHIFT_W
// BEHAVIOUR
// - Reset: every output, shreg, bank and synchroniser flop goes to 0; rx_state=IDLE.
//   Reset is async assert, sync release.
// - Input sync: serial, sclk, gsclk and each lat[i] pass through 2 sync flops.
//   Edge detect compares the sync output with one more delayed copy.
// - Input-to-action latency is 3 clk; serial takes the same delay, so data stays aligned to sclk.
// - Only rising edges act; a lat held high for many cycles latches once.
// - Shift, on a sync sclk rise: shreg <= {shreg[SHIFT_W-2:0], serial_s}, MSB first.
//   - bit_cnt below SHIFT_W: increment bit_cnt.
//   - bit_cnt == SHIFT_W: set err_overrun, still shift (oldest bit lost), bit_cnt stays.
// - Latch, on a sync lat[i] rise: bank lane i <= post-shift shreg value.
//   - bit_cnt <= 0; gs_count <= 0; latch_pulse=1 for 1 cycle.
//   - err_short set if the pre-latch bit_cnt != SHIFT_W; the latch is still performed.
//   - Several lanes rising in one cycle: all of them update; latch_idx = lowest index.
//   - shreg is not cleared by a latch.
// - Simultaneous sclk and lat edges in one cycle: the shift is applied first.
//   - The latch then captures the shifted value; the bit is counted in the err_short check.
//   - bit_cnt ends at 0.
// - rx_state is registered from the next bit_cnt: 0 -> IDLE, 1..SHIFT_W-1 -> SHIFTING,
//   SHIFT_W -> FULL.
// - Transitions: IDLE->SHIFTING on the first shift; SHIFTING->FULL on the SHIFT_W-th shift;
//   any state->IDLE on a latch.
// - gsclk: gs_count increments on each sync gsclk rise. At 2^GS_W-1 it wraps to 0 and pulses
//   gs_wrap. A latch in the same cycle wins: gs_count=0, no gs_wrap.
// - err_clr clears both sticky flags. If an error event occurs in the same cycle, the event
//   wins and the flag stays set.
// - Reset mid-frame discards the partial shreg, bit_cnt and the banks.
// STRUCTURE
// - Shared package led_if_pkg: NUM_LAT, SHIFT_W and GS_W defaults; rx_state encodings
//   (RX_IDLE/RX_SHIFTING/RX_FULL); controller op-code constants (SEND_LATCH=4, etc.),
//   so bench and controller stay consistent.
// - Sub-module sync_edge: 2-flop synchroniser plus rising-edge detector.
//   - Outputs the synced level and a rise pulse; async active-low reset.
//   - Instantiated for sclk, serial (level only), gsclk and each lat bit.
// TESTING
// - Full frame: 48 sclk edges carrying 0xA5A5_0F0F_1234, then lat[2] rise.
//   -> bank lane 2 == 0xA5A5_0F0F_1234; latch_idx=2; latch_pulse for 1 cycle;
//      bit_cnt=0; no error flags.
// - Short frame: 10 sclk edges, then lat[0].
//   -> err_short=1; lane 0 holds shreg; err_clr then clears the flag.
// - Overrun: 50 sclk edges, then lat[1].
//   -> err_overrun=1; rx_state=FULL after edge 48; lane 1 = last 48 bits; err_short=0.
// - Lat held high 20 cycles, with lat[0] and lat[3] rising together.
//   -> exactly one latch_pulse; both lanes equal; latch_idx=0.
// - gsclk: 4096 rises -> gs_count back to 0 with one gs_wrap pulse; a following latch
//   clears gs_count.
// - rst_n dropped after 20 of 48 bits.
//   -> all outputs 0 immediately (async); after release a fresh 48-bit frame latches cleanly.

Source files
------------

// File: rtl/led_if_pkg.sv
// Shared constants for the LED serial link: default geometry, receiver state
// encodings and controller op-codes used by both ends of the link.
package led_if_pkg;

    localparam int LED_SHIFT_W = 48;
    localparam int LED_NUM_LAT = 4;
    localparam int LED_GS_W    = 12;

    typedef enum logic [1:0] {
        RX_IDLE     = 2'd0,
        RX_SHIFTING = 2'd1,
        RX_FULL     = 2'd2
    } rx_state_t;

    typedef enum logic [2:0] {
        SEND_NOP   = 3'd0,
        SEND_BIT0  = 3'd1,
        SEND_BIT1  = 3'd2,
        SEND_GSCLK = 3'd3,
        SEND_LATCH = 3'd4
    } led_op_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous input, followed by a delayed copy
// used to detect rising edges of the synchronised level.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise
);

    logic s_meta;
    logic s_sync;
    logic s_dly;

    // NOTE: non-blocking assignments let each flop sample the previous stage's
    // old value; blocking here would collapse the chain into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta <= 1'b0;
            s_sync <= 1'b0;
            s_dly  <= 1'b0;
        end else begin
            s_meta <= d;
            s_sync <= s_meta;
            s_dly  <= s_sync;
        end
    end

    assign level = s_sync;
    assign rise  = s_sync & ~s_dly;

endmodule

// File: rtl/led_serial_receiver.sv
// Receive end of the LED serial link: shifts synchronised serial data on sclk,
// commits frames into per-lane banks on lat, counts gsclk and flags framing errors.
module led_serial_receiver
    import led_if_pkg::*;
#(
    parameter int SHIFT_W = LED_SHIFT_W,
    parameter int NUM_LAT = LED_NUM_LAT,
    parameter int GS_W    = LED_GS_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         serial,
    input  logic                         sclk,
    input  logic [NUM_LAT-1:0]           lat,
    input  logic                         gsclk,
    input  logic                         err_clr,
    output logic [NUM_LAT*SHIFT_W-1:0]   bank,
    output logic                         latch_pulse,
    output logic [1:0]                   latch_idx,
    output logic [$clog2(SHIFT_W+1)-1:0] bit_cnt,
    output logic [1:0]                   rx_state,
    output logic [GS_W-1:0]              gs_count,
    output logic                         gs_wrap,
    output logic                         err_overrun,
    output logic                         err_short
);

    localparam int               CNT_W    = $clog2(SHIFT_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SHIFT_W);

    logic               serial_s;
    logic               serial_rise_unused;
    logic               sclk_level_unused;
    logic               sclk_rise;
    logic               gsclk_level_unused;
    logic               gsclk_rise;
    logic [NUM_LAT-1:0] lat_level_unused;
    logic [NUM_LAT-1:0] lat_rise;

    sync_edge u_sync_serial (.clk(clk), .rst_n(rst_n), .d(serial), .level(serial_s),           .rise(serial_rise_unused));
    sync_edge u_sync_sclk   (.clk(clk), .rst_n(rst_n), .d(sclk),   .level(sclk_level_unused),  .rise(sclk_rise));
    sync_edge u_sync_gsclk  (.clk(clk), .rst_n(rst_n), .d(gsclk),  .level(gsclk_level_unused), .rise(gsclk_rise));

    for (genvar i = 0; i < NUM_LAT; i++) begin : g_lat_sync
        sync_edge u_sync_lat (.clk(clk), .rst_n(rst_n), .d(lat[i]), .level(lat_level_unused[i]), .rise(lat_rise[i]));
    end

    logic [SHIFT_W-1:0] shreg;
    logic [SHIFT_W-1:0] shreg_nxt;
    logic [CNT_W-1:0]   cnt_shift;
    logic [CNT_W-1:0]   bit_cnt_nxt;
    logic               latch_any;
    logic [1:0]         latch_idx_nxt;
    logic               overrun_evt;
    logic               short_evt;
    logic [GS_W-1:0]    gs_count_nxt;
    logic               gs_wrap_nxt;
    rx_state_t          state;
    rx_state_t          state_nxt;

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        shreg_nxt     = shreg;
        cnt_shift     = bit_cnt;
        overrun_evt   = 1'b0;
        latch_idx_nxt = latch_idx;
        gs_count_nxt  = gs_count;
        gs_wrap_nxt   = 1'b0;

        // Shift first, so a same-cycle latch captures and counts the new bit.
        if (sclk_rise) begin
            shreg_nxt = {shreg[SHIFT_W-2:0], serial_s};
            if (bit_cnt == CNT_FULL) overrun_evt = 1'b1;
            else                     cnt_shift   = bit_cnt + CNT_W'(1);
        end

        latch_any   = |lat_rise;
        short_evt   = latch_any && (cnt_shift != CNT_FULL);
        bit_cnt_nxt = latch_any ? '0 : cnt_shift;

        for (int i = NUM_LAT - 1; i >= 0; i--) begin
            if (lat_rise[i]) latch_idx_nxt = 2'(i);
        end

        if (latch_any) begin
            gs_count_nxt = '0;
        end else if (gsclk_rise) begin
            gs_count_nxt = gs_count + GS_W'(1);
            gs_wrap_nxt  = (gs_count == '1);
        end
    end

    always_comb begin
        state_nxt = RX_SHIFTING;
        if (bit_cnt_nxt == '0)            state_nxt = RX_IDLE;
        else if (bit_cnt_nxt == CNT_FULL) state_nxt = RX_FULL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RX_IDLE;
        else        state <= state_nxt;
    end

    assign rx_state = state;

    // NOTE: the banks are reset because a reset must discard any committed
    // frame; storage with no such visible contract would be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            bank        <= '0;
            latch_pulse <= 1'b0;
            latch_idx   <= '0;
            gs_count    <= '0;
            gs_wrap     <= 1'b0;
            err_overrun <= 1'b0;
            err_short   <= 1'b0;
        end else begin
            shreg       <= shreg_nxt;
            bit_cnt     <= bit_cnt_nxt;
            latch_pulse <= latch_any;
            latch_idx   <= latch_idx_nxt;
            gs_count    <= gs_count_nxt;
            gs_wrap     <= gs_wrap_nxt;
            for (int i = 0; i < NUM_LAT; i++) begin
                if (lat_rise[i]) bank[i*SHIFT_W +: SHIFT_W] <= shreg_nxt;
            end
            // An error event in the same cycle as err_clr keeps the flag set.
            if (overrun_evt)  err_overrun <= 1'b1;
            else if (err_clr) err_overrun <= 1'b0;
            if (short_evt)    err_short   <= 1'b1;
            else if (err_clr) err_short   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_serial_receiver.sv
// Self-checking bench for led_serial_receiver: a bit-level model predicts each
// latch, and a monitor compares every latch_pulse against the queued prediction.
module tb_led_serial_receiver;
    import led_if_pkg::*;

    localparam int SW = 48;
    localparam int NL = 4;
    localparam int GW = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              serial;
    logic              sclk;
    logic [NL-1:0]     lat;
    logic              gsclk;
    logic              err_clr;
    logic [NL*SW-1:0]  bank;
    logic              latch_pulse;
    logic [1:0]        latch_idx;
    logic [5:0]        bit_cnt;
    logic [1:0]        rx_state;
    logic [GW-1:0]     gs_count;
    logic              gs_wrap;
    logic              err_overrun;
    logic              err_short;

    led_serial_receiver #(.SHIFT_W(SW), .NUM_LAT(NL), .GS_W(GW)) dut (
        .clk(clk), .rst_n(rst_n), .serial(serial), .sclk(sclk), .lat(lat),
        .gsclk(gsclk), .err_clr(err_clr), .bank(bank), .latch_pulse(latch_pulse),
        .latch_idx(latch_idx), .bit_cnt(bit_cnt), .rx_state(rx_state),
        .gs_count(gs_count), .gs_wrap(gs_wrap), .err_overrun(err_overrun),
        .err_short(err_short)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [NL-1:0] mask;
        logic [1:0]    idx;
        logic [SW-1:0] data;
        logic          es;
        logic          eo;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   pulse_cnt = 0;
    int   wrap_cnt  = 0;

    logic [SW-1:0] m_shreg;
    int            m_cnt;
    logic          m_short;
    logic          m_over;

    always @(negedge clk) begin
        if (rst_n && latch_pulse) begin
            pulse_cnt++;
            check("pulse_has_expect", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                for (int i = 0; i < NL; i++) begin
                    if (mon_e.mask[i]) check($sformatf("bank_lane%0d", i), 64'(bank[i*SW +: SW]), 64'(mon_e.data));
                end
                check("latch_idx",    64'(latch_idx),   64'(mon_e.idx));
                check("bit_cnt_lat",  64'(bit_cnt),     64'd0);
                check("state_lat",    64'(rx_state),    64'(RX_IDLE));
                check("gs_count_lat", 64'(gs_count),    64'd0);
                check("err_short",    64'(err_short),   64'(mon_e.es));
                check("err_overrun",  64'(err_overrun), 64'(mon_e.eo));
            end
        end
        if (rst_n && gs_wrap) wrap_cnt++;
    end

    task automatic model_reset();
        m_shreg = '0;
        m_cnt   = 0;
        m_short = 1'b0;
        m_over  = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        serial = b;
        sclk   = 1'b1;
        repeat (2) @(negedge clk);
        sclk   = 1'b0;
        repeat (2) @(negedge clk);
        if (m_cnt == SW) m_over = 1'b1;
        else             m_cnt++;
        m_shreg = {m_shreg[SW-2:0], b};
    endtask

    task automatic send_bits(input logic [SW-1:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[SW-1-i]);
    endtask

    task automatic do_latch(input logic [NL-1:0] mask, input int hold);
        exp_t e;
        e.idx = 2'd0;
        for (int i = NL - 1; i >= 0; i--) if (mask[i]) e.idx = 2'(i);
        if (m_cnt != SW) m_short = 1'b1;
        m_cnt  = 0;
        e.mask = mask;
        e.data = m_shreg;
        e.es   = m_short;
        e.eo   = m_over;
        sb.push_back(e);
        lat = mask;
        repeat (hold) @(negedge clk);
        lat = '0;
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check("latch_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_short = 1'b0;
        m_over  = 1'b0;
        @(negedge clk);
        check("clr_short",   64'(err_short),   64'd0);
        check("clr_overrun", 64'(err_overrun), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bank"},    64'(bank == '0), 64'd1);
        check({tag, "_bitcnt"},  64'(bit_cnt),    64'd0);
        check({tag, "_state"},   64'(rx_state),   64'(RX_IDLE));
        check({tag, "_pulse"},   64'(latch_pulse), 64'd0);
        check({tag, "_idx"},     64'(latch_idx),  64'd0);
        check({tag, "_gs"},      64'(gs_count),   64'd0);
        check({tag, "_wrap"},    64'(gs_wrap),    64'd0);
        check({tag, "_errs"},    64'({err_short, err_overrun}), 64'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SW-1:0] w;
        int            p0;

        rst_n = 1'b0; serial = 1'b0; sclk = 1'b0; lat = '0; gsclk = 1'b0; err_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full frame into lane 2.
        send_bits(48'hA5A5_0F0F_1234, SW);
        check("full_bitcnt", 64'(bit_cnt),  64'(SW));
        check("full_state",  64'(rx_state), 64'(RX_FULL));
        do_latch(4'b0100, 3);
        check("full_lane2_const", 64'(bank[2*SW +: SW]), 64'h0000_A5A5_0F0F_1234);
        check("full_pulse_gone",  64'(latch_pulse), 64'd0);

        // Short frame into lane 0, then clear the sticky flag.
        send_bits(48'h3C5_0000_0000 << 4, 10);
        check("short_bitcnt", 64'(bit_cnt),  64'd10);
        check("short_state",  64'(rx_state), 64'(RX_SHIFTING));
        do_latch(4'b0001, 3);
        clear_errs();

        // Overrun: 50 edges, FULL after the 48th.
        w = {$urandom, $urandom};
        send_bits(w, SW);
        check("ovr_state48",  64'(rx_state),    64'(RX_FULL));
        check("ovr_flag48",   64'(err_overrun), 64'd0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("ovr_flag50",   64'(err_overrun), 64'd1);
        check("ovr_bitcnt",   64'(bit_cnt),     64'(SW));
        do_latch(4'b0010, 3);
        clear_errs();

        // Lat held high for 20 cycles on lanes 0 and 3 together.
        w = {$urandom, $urandom};
        send_bits(w, SW);
        p0 = pulse_cnt;
        do_latch(4'b1001, 20);
        repeat (5) @(negedge clk);
        check("held_pulses", 64'(pulse_cnt - p0), 64'd1);
        check("held_lanes_eq", 64'(bank[0 +: SW] == bank[3*SW +: SW]), 64'd1);

        // Grayscale counter wrap, then a latch clears it.
        for (int i = 0; i < (1 << GW) - 1; i++) begin
            gsclk = 1'b1; @(negedge clk);
            gsclk = 1'b0; @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("gs_max",       64'(gs_count), 64'((1 << GW) - 1));
        check("gs_no_wrap",   64'(wrap_cnt), 64'd0);
        gsclk = 1'b1; @(negedge clk);
        gsclk = 1'b0;
        repeat (4) @(negedge clk);
        check("gs_wrapped",   64'(gs_count), 64'd0);
        check("gs_wrap_once", 64'(wrap_cnt), 64'd1);
        for (int i = 0; i < 3; i++) begin
            gsclk = 1'b1; @(negedge clk);
            gsclk = 1'b0; @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("gs_three", 64'(gs_count), 64'd3);
        do_latch(4'b0010, 3);
        clear_errs();

        // Reset in the middle of a frame, then a clean frame.
        w = {$urandom, $urandom};
        send_bits(w, 20);
        check("mid_bitcnt", 64'(bit_cnt), 64'd20);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        w = {$urandom, $urandom};
        send_bits(w, SW);
        do_latch(4'b1000, 3);
        check("post_rst_lane3", 64'(bank[3*SW +: SW]), 64'(w));
        check("post_rst_other", 64'(bank[0 +: 3*SW] == '0), 64'd1);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
